// File: rtl/mem_bus_if.sv
// Word-addressed load/store bus with an active-low request/ready handshake.
// The MEM stage is the master; memory or the bench is the slave.
interface mem_bus_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
);
    logic              bus_req_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_, bus_rw, bus_addr, bus_wr_data,
        input  bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_rw, bus_addr, bus_wr_data,
        output bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs word load/store bus accesses for EX results and
// registers the GPR write-back triple; stalls upstream through mem_busy.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 30,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_en,
    input  logic [1:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_out,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [REG_AW-1:0] ex_dst_addr,
    input  logic              ex_gpr_we_,
    mem_bus_if.master         bus,
    output logic              mem_busy,
    output logic              miss_align,
    output logic              bus_err,
    output logic              gpr_we_,
    output logic [REG_AW-1:0] gpr_wr_addr,
    output logic [DATA_W-1:0] gpr_wr_data
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] OP_LW = 2'b01;
    localparam logic [1:0] OP_SW = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic                we_lat_q, we_lat_d;
    logic                kill_q, kill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                gpr_we_q, gpr_we_d;
    logic [REG_AW-1:0]   gpr_addr_q, gpr_addr_d;
    logic [DATA_W-1:0]   gpr_data_q, gpr_data_d;
    logic                miss_q, miss_d;
    logic                err_q, err_d;

    logic is_mem, aligned, timeout_hit;

    assign is_mem  = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
    assign aligned = (ex_out[1:0] == 2'b00);
    // Abort on the TIMEOUT-th ACCESS cycle; a ready on that same edge still wins.
    assign timeout_hit = (TIMEOUT > 0) && ((int'(cnt_q) + 1) >= TIMEOUT);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dst_d      = dst_q;
        we_lat_d   = we_lat_q;
        kill_d     = kill_q;
        cnt_d      = cnt_q;
        gpr_we_d   = 1'b1;
        gpr_addr_d = gpr_addr_q;
        gpr_data_d = gpr_data_q;
        miss_d     = 1'b0;
        err_d      = 1'b0;
        mem_busy   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_en && !flush) begin
                    if (is_mem) begin
                        if (!aligned) begin
                            miss_d = 1'b1;
                        end else begin
                            mem_busy = 1'b1;
                            state_d  = ACCESS;
                            req_d    = 1'b0;
                            rw_d     = (ex_mem_op == OP_LW);
                            addr_d   = ex_out[ADDR_W+1:2];
                            wdata_d  = ex_st_data;
                            dst_d    = ex_dst_addr;
                            we_lat_d = ex_gpr_we_;
                            kill_d   = 1'b0;
                            cnt_d    = '0;
                        end
                    end else begin
                        gpr_we_d   = ex_gpr_we_;
                        gpr_addr_d = ex_dst_addr;
                        gpr_data_d = ex_out;
                    end
                end
            end

            ACCESS: begin
                // A flush never aborts the bus cycle, it only drops the write-back.
                if (flush) kill_d = 1'b1;
                if (!bus.bus_rdy_) begin
                    req_d   = 1'b1;
                    state_d = IDLE;
                    if (rw_q) begin
                        gpr_we_d   = we_lat_q | kill_q | flush;
                        gpr_addr_d = dst_q;
                        gpr_data_d = bus.bus_rd_data;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_busy = 1'b1;
                    if (TIMEOUT > 0 && cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b1;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            dst_q      <= '0;
            we_lat_q   <= 1'b1;
            kill_q     <= 1'b0;
            cnt_q      <= '0;
            gpr_we_q   <= 1'b1;
            gpr_addr_q <= '0;
            gpr_data_q <= '0;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dst_q      <= dst_d;
            we_lat_q   <= we_lat_d;
            kill_q     <= kill_d;
            cnt_q      <= cnt_d;
            gpr_we_q   <= gpr_we_d;
            gpr_addr_q <= gpr_addr_d;
            gpr_data_q <= gpr_data_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
        end
    end

    assign bus.bus_req_    = req_q;
    assign bus.bus_rw      = rw_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wr_data = wdata_q;
    assign miss_align      = miss_q;
    assign bus_err         = err_q;
    assign gpr_we_         = gpr_we_q;
    assign gpr_wr_addr     = gpr_addr_q;
    assign gpr_wr_data     = gpr_data_q;

endmodule
